// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing the reg_file access port between the core (C) and debug (D).
// Optional stall counter on the core port: define REG_ARB_STALL_CNT_EN.
package reg_port_arbiter_pkg;
  typedef enum logic [1:0] {
    READ_REG_DATA  = 2'd0,
    WRITE_REG_DATA = 2'd1
  } reg_file_op_t;
endpackage

module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE = 32
`ifdef REG_ARB_STALL_CNT_EN
  , parameter int unsigned STALL_CNT_W = 16
`endif
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 c_valid,
  input  logic                 c_write,
  input  logic [4:0]           c_rs1,
  input  logic [4:0]           c_rs2,
  input  logic [4:0]           c_rd,
  input  logic [WORD_SIZE-1:0] c_wdata,
  output logic                 c_ready,
  input  logic                 d_valid,
  input  logic                 d_write,
  input  logic [4:0]           d_rs1,
  input  logic [4:0]           d_rs2,
  input  logic [4:0]           d_rd,
  input  logic [WORD_SIZE-1:0] d_wdata,
  input  logic                 d_lock,
  output logic                 d_ready,
  output reg_file_op_t         rf_mem_op,
  output logic [4:0]           rf_rs1,
  output logic [4:0]           rf_rs2,
  output logic [4:0]           rf_rd,
  output logic [WORD_SIZE-1:0] rf_write_data,
  input  logic [WORD_SIZE-1:0] rf_rs1_data,
  input  logic [WORD_SIZE-1:0] rf_rs2_data,
  output logic                 rsp_valid,
  output logic                 rsp_id,
  output logic                 rsp_is_write,
  output logic [WORD_SIZE-1:0] rsp_rs1_data,
  output logic [WORD_SIZE-1:0] rsp_rs2_data,
`ifdef REG_ARB_STALL_CNT_EN
  input  logic                 c_stall_clr,
  output logic [STALL_CNT_W-1:0] c_stall_cnt,
`endif
  output logic                 dbg_halted
);

  typedef enum logic {
    RUN    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef enum logic {
    REQ_C = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  state_t  state, state_next;
  req_id_t rr_last;
  logic    c_grant, d_grant;
  logic    xfer, xfer_write;

  // A grant is only ever given to a valid requester, so grant == transfer.
  always_comb begin
    c_grant = 1'b0;
    d_grant = 1'b0;
    if (state == LOCKED) begin
      d_grant = d_valid;
    end else if (c_valid && d_valid) begin
      c_grant = (rr_last == REQ_D);
      d_grant = (rr_last == REQ_C);
    end else begin
      c_grant = c_valid;
      d_grant = d_valid;
    end
  end

  assign c_ready    = c_grant;
  assign d_ready    = d_grant;
  assign xfer       = c_grant | d_grant;
  assign xfer_write = c_grant ? c_write : (d_grant & d_write);

  always_comb begin
    rf_mem_op     = READ_REG_DATA;
    rf_rs1        = '0;
    rf_rs2        = '0;
    rf_rd         = '0;
    rf_write_data = '0;
    if (c_grant) begin
      rf_mem_op     = c_write ? WRITE_REG_DATA : READ_REG_DATA;
      rf_rs1        = c_rs1;
      rf_rs2        = c_rs2;
      rf_rd         = c_rd;
      rf_write_data = c_wdata;
    end else if (d_grant) begin
      rf_mem_op     = d_write ? WRITE_REG_DATA : READ_REG_DATA;
      rf_rs1        = d_rs1;
      rf_rs2        = d_rs2;
      rf_rd         = d_rd;
      rf_write_data = d_wdata;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (d_grant && d_lock) state_next = LOCKED;
      LOCKED:  if (!d_lock) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= RUN;
      rr_last      <= REQ_D;
      dbg_halted   <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_is_write <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
    end else begin
      state        <= state_next;
      dbg_halted   <= (state_next == LOCKED);
      if (c_grant) rr_last <= REQ_C;
      else if (d_grant) rr_last <= REQ_D;
      rsp_valid    <= xfer;
      rsp_id       <= d_grant;
      rsp_is_write <= xfer & xfer_write;
      rsp_rs1_data <= (xfer && !xfer_write) ? rf_rs1_data : '0;
      rsp_rs2_data <= (xfer && !xfer_write) ? rf_rs2_data : '0;
    end
  end

`ifdef REG_ARB_STALL_CNT_EN
  always_ff @(posedge clock) begin
    if (reset || c_stall_clr) begin
      c_stall_cnt <= '0;
    end else if (c_valid && !c_grant && (c_stall_cnt != '1)) begin
      c_stall_cnt <= c_stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Table-driven bench for reg_port_arbiter with a behavioural reg_file and a response scoreboard.
module tb_reg_port_arbiter;
  import reg_port_arbiter_pkg::*;

  localparam int unsigned W = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic         reset = 1'b1;
  logic         c_valid = 1'b0, c_write = 1'b0;
  logic [4:0]   c_rs1 = '0, c_rs2 = '0, c_rd = '0;
  logic [W-1:0] c_wdata = '0;
  logic         c_ready;
  logic         d_valid = 1'b0, d_write = 1'b0, d_lock = 1'b0;
  logic [4:0]   d_rs1 = '0, d_rs2 = '0, d_rd = '0;
  logic [W-1:0] d_wdata = '0;
  logic         d_ready;
  reg_file_op_t rf_mem_op;
  logic [4:0]   rf_rs1, rf_rs2, rf_rd;
  logic [W-1:0] rf_write_data, rf_rs1_data, rf_rs2_data;
  logic         rsp_valid, rsp_id, rsp_is_write, dbg_halted;
  logic [W-1:0] rsp_rs1_data, rsp_rs2_data;
`ifdef REG_ARB_STALL_CNT_EN
  logic         c_stall_clr = 1'b0;
  logic [15:0]  c_stall_cnt;
`endif

  reg_port_arbiter #(.WORD_SIZE(W)) dut (
    .clock(clock), .reset(reset),
    .c_valid(c_valid), .c_write(c_write), .c_rs1(c_rs1), .c_rs2(c_rs2), .c_rd(c_rd),
    .c_wdata(c_wdata), .c_ready(c_ready),
    .d_valid(d_valid), .d_write(d_write), .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd),
    .d_wdata(d_wdata), .d_lock(d_lock), .d_ready(d_ready),
    .rf_mem_op(rf_mem_op), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_rd(rf_rd),
    .rf_write_data(rf_write_data), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_is_write(rsp_is_write),
    .rsp_rs1_data(rsp_rs1_data), .rsp_rs2_data(rsp_rs2_data),
`ifdef REG_ARB_STALL_CNT_EN
    .c_stall_clr(c_stall_clr), .c_stall_cnt(c_stall_cnt),
`endif
    .dbg_halted(dbg_halted)
  );

  // Behavioural reg_file: no reset, x0 writes discarded, combinational read.
  logic [W-1:0] mem [32] = '{default: '0};
  always @(posedge clock)
    if (rf_mem_op == WRITE_REG_DATA && rf_rd != 5'd0) mem[rf_rd] <= rf_write_data;
  assign rf_rs1_data = mem[rf_rs1];
  assign rf_rs2_data = mem[rf_rs2];

  typedef struct {
    bit           v, w;
    logic [4:0]   rs1, rs2, rd;
    logic [W-1:0] wdata;
  } req_t;

  typedef struct {
    bit   rst;
    req_t c, d;
    bit   lock, ec, ed, eh;
  } vec_t;

  typedef struct {
    logic         id, wr;
    logic [W-1:0] d1, d2;
  } rsp_t;

  int   n_chk = 0, n_fail = 0;
  rsp_t sb[$];
  vec_t tbl[$];

  function automatic req_t IDLE();
    req_t r = '{v: 0, w: 0, rs1: '0, rs2: '0, rd: '0, wdata: '0};
    return r;
  endfunction
  function automatic req_t RD(input logic [4:0] a, input logic [4:0] b);
    req_t r = '{v: 1, w: 0, rs1: a, rs2: b, rd: '0, wdata: '0};
    return r;
  endfunction
  function automatic req_t WR(input logic [4:0] d, input logic [W-1:0] x);
    req_t r = '{v: 1, w: 1, rs1: '0, rs2: '0, rd: d, wdata: x};
    return r;
  endfunction
  function automatic vec_t mk(input bit rst, input req_t c, input req_t d, input bit lock,
                              input bit ec, input bit ed, input bit eh);
    vec_t v = '{rst: rst, c: c, d: d, lock: lock, ec: ec, ed: ed, eh: eh};
    return v;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic id, input req_t r);
    rsp_t e;
    e.id = id;
    e.wr = r.w;
    e.d1 = r.w ? '0 : mem[r.rs1];
    e.d2 = r.w ? '0 : mem[r.rs2];
    sb.push_back(e);
  endtask

  task automatic do_cycle(input vec_t v);
    rsp_t e;
    reset   = v.rst;
    c_valid = v.c.v; c_write = v.c.w; c_rs1 = v.c.rs1; c_rs2 = v.c.rs2; c_rd = v.c.rd;
    c_wdata = v.c.wdata;
    d_valid = v.d.v; d_write = v.d.w; d_rs1 = v.d.rs1; d_rs2 = v.d.rs2; d_rd = v.d.rd;
    d_wdata = v.d.wdata; d_lock = v.lock;
    #1;
    chk("c_ready", c_ready, v.ec);
    chk("d_ready", d_ready, v.ed);
    if (v.ec || v.ed) begin
      chk("rf_mem_op", rf_mem_op, (v.ec ? v.c.w : v.d.w) ? WRITE_REG_DATA : READ_REG_DATA);
      chk("rf_rs1", rf_rs1, v.ec ? v.c.rs1 : v.d.rs1);
      if (!v.rst) push_exp(v.ed, v.ec ? v.c : v.d);
    end else begin
      chk("rf_idle_op", rf_mem_op, READ_REG_DATA);
      chk("rf_idle_fields", {rf_rs1, rf_rs2, rf_rd}, '0);
      chk("rf_idle_wdata", rf_write_data, '0);
    end
    @(posedge clock);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("rsp_valid", rsp_valid, 1'b1);
      chk("rsp_id", rsp_id, e.id);
      chk("rsp_is_write", rsp_is_write, e.wr);
      chk("rsp_rs1_data", rsp_rs1_data, e.d1);
      chk("rsp_rs2_data", rsp_rs2_data, e.d2);
    end else begin
      chk("rsp_valid_idle", rsp_valid, 1'b0);
    end
    chk("dbg_halted", dbg_halted, v.eh);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Write/read-after-write
    tbl.push_back(mk(0, WR(5, 32'hDEADBEEF), IDLE(), 0, 1, 0, 0));
    tbl.push_back(mk(0, RD(5, 0),            IDLE(), 0, 1, 0, 0));
    tbl.push_back(mk(0, WR(1, 32'h11111111), IDLE(), 0, 1, 0, 0));
    tbl.push_back(mk(0, IDLE(), WR(2, 32'h22222222), 0, 0, 1, 0));
    // Contention: rr_last is D, so C,D,C,D
    tbl.push_back(mk(0, RD(1, 5), RD(1, 2), 0, 1, 0, 0));
    tbl.push_back(mk(0, RD(1, 5), RD(1, 2), 0, 0, 1, 0));
    tbl.push_back(mk(0, RD(1, 5), RD(1, 2), 0, 1, 0, 0));
    tbl.push_back(mk(0, RD(1, 5), RD(1, 2), 0, 0, 1, 0));
    // x0 write is acknowledged but discarded
    tbl.push_back(mk(0, WR(0, 32'h00001234), IDLE(), 0, 1, 0, 0));
    tbl.push_back(mk(0, RD(0, 0),            IDLE(), 0, 1, 0, 0));
    // Debug lock with core waiting
    tbl.push_back(mk(0, RD(1, 1), RD(2, 5), 1, 0, 1, 1));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0, RD(1, 1), IDLE(), 1, 0, 0, 1));
    tbl.push_back(mk(0, RD(1, 1), RD(5, 1), 1, 0, 1, 1));
    tbl.push_back(mk(0, RD(1, 1), RD(2, 2), 0, 0, 1, 0));
    tbl.push_back(mk(0, RD(1, 1), IDLE(),   0, 1, 0, 0));
    // Reset after a read, then tie goes to core
    tbl.push_back(mk(0, RD(5, 5), IDLE(),   0, 1, 0, 0));
    tbl.push_back(mk(1, IDLE(),   IDLE(),   0, 0, 0, 0));
    tbl.push_back(mk(0, RD(1, 2), RD(5, 5), 0, 1, 0, 0));
    // Reset while locked; write in reset cycle still reaches reg_file
    tbl.push_back(mk(0, IDLE(), RD(1, 1), 1, 0, 1, 1));
    tbl.push_back(mk(1, IDLE(), IDLE(),   1, 0, 0, 0));
    tbl.push_back(mk(1, WR(7, 32'h77777777), IDLE(), 0, 1, 0, 0));
    tbl.push_back(mk(0, RD(7, 1), RD(7, 7), 0, 1, 0, 0));
    tbl.push_back(mk(0, IDLE(), IDLE(), 0, 0, 0, 0));

    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_id", rsp_id, 1'b0);
    chk("reset_rsp_is_write", rsp_is_write, 1'b0);
    chk("reset_rsp_data", rsp_rs1_data | rsp_rs2_data, '0);
    chk("reset_dbg_halted", dbg_halted, 1'b0);
    reset = 1'b0;

    foreach (tbl[i]) do_cycle(tbl[i]);

`ifdef REG_ARB_STALL_CNT_EN
    d_valid = 1'b1; d_write = 1'b0; d_lock = 1'b1;
    @(posedge clock); #1;
    d_valid = 1'b0; c_valid = 1'b1; c_write = 1'b0; c_stall_clr = 1'b1;
    @(posedge clock); #1;
    c_stall_clr = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("stall_cnt_10", c_stall_cnt, 16'd10);
    c_valid = 1'b0; c_stall_clr = 1'b1;
    @(posedge clock); #1;
    chk("stall_cnt_clr", c_stall_cnt, 16'd0);
    c_stall_clr = 1'b0; c_valid = 1'b1;
    repeat (65540) @(posedge clock);
    #1;
    chk("stall_cnt_sat", c_stall_cnt, 16'hFFFF);
    c_valid = 1'b0; d_lock = 1'b0;
    repeat (2) @(posedge clock);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
